// File: rtl/fifo_pkt_writer.sv
// Write-side packet producer for the async FIFO (wclk domain).
// Skid-buffers a valid/ready stream, truncates long packets, writes {last, data}.
module fifo_pkt_writer #(
  parameter int WIDTH = 8,
  parameter int MAX_PKT = 64,
  localparam int LEN_W = $clog2(MAX_PKT + 1)
) (
  input  logic             wclk,
  input  logic             w_rst_n,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_last,
  output logic             fifo_wr_en,
  output logic [WIDTH:0]   fifo_wr_data,
  input  logic             fifo_full,
  output logic             pkt_done,
  output logic [LEN_W-1:0] pkt_len,
  output logic             trunc_err,
  output logic [15:0]      pkt_cnt,
  output logic [15:0]      drop_cnt
);

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DROP
  } state_t;

  typedef struct packed {
    logic             last;
    logic [WIDTH-1:0] data;
  } word_t;

  state_t           state;
  word_t            ent0;
  word_t            ent1;
  word_t            in_word;
  logic [1:0]       occ;
  logic [1:0]       occ_next;
  logic [1:0]       slot;
  logic [LEN_W-1:0] beat_cnt;
  logic [LEN_W-1:0] wr_len;
  logic             accept;
  logic             push;
  logic             pop;
  logic             at_limit;

  assign accept   = s_valid && s_ready;
  assign at_limit = beat_cnt == LEN_W'(MAX_PKT - 1);
  assign push     = accept && (state != DROP);
  assign pop      = (occ != 2'd0) && !fifo_full;
  assign slot     = occ - {1'b0, pop};

  // The MAX_PKT-th beat of an unterminated packet closes it
  assign in_word = {
    s_last || (state == ACTIVE && at_limit),
    s_data
  };

  assign fifo_wr_en   = pop;
  assign fifo_wr_data = ent0;

  always_comb begin
    occ_next = occ;
    unique case ({push, pop})
      2'b10:   occ_next = occ + 2'd1;
      2'b01:   occ_next = occ - 2'd1;
      default: occ_next = occ;
    endcase
  end

  // Skid storage: ent0 is always the head
  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      occ     <= 2'd0;
      ent0    <= '0;
      ent1    <= '0;
      s_ready <= 1'b0;
    end else begin
      occ     <= occ_next;
      s_ready <= occ_next < 2'd2;
      if (pop)
        ent0 <= ent1;
      if (push) begin
        if (slot == 2'd0)
          ent0 <= in_word;
        else
          ent1 <= in_word;
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      state     <= IDLE;
      beat_cnt  <= '0;
      trunc_err <= 1'b0;
      drop_cnt  <= '0;
    end else begin
      trunc_err <= 1'b0;
      if (accept) begin
        unique case (state)
          IDLE: begin
            if (!s_last) begin
              state    <= ACTIVE;
              beat_cnt <= LEN_W'(1);
            end
          end
          ACTIVE: begin
            if (s_last) begin
              state    <= IDLE;
              beat_cnt <= '0;
            end else if (at_limit) begin
              state     <= DROP;
              beat_cnt  <= '0;
              trunc_err <= 1'b1;
            end else begin
              beat_cnt <= beat_cnt + LEN_W'(1);
            end
          end
          DROP: begin
            if (drop_cnt != 16'hFFFF)
              drop_cnt <= drop_cnt + 16'd1;
            if (s_last)
              state <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge wclk) begin
    if (!w_rst_n) begin
      wr_len   <= '0;
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      pkt_cnt  <= '0;
    end else begin
      pkt_done <= 1'b0;
      pkt_len  <= '0;
      if (pop) begin
        if (ent0.last) begin
          pkt_done <= 1'b1;
          pkt_len  <= wr_len + LEN_W'(1);
          pkt_cnt  <= pkt_cnt + 16'd1;
          wr_len   <= '0;
        end else begin
          wr_len <= wr_len + LEN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_pkt_writer.sv
// Bench for fifo_pkt_writer: MAX_PKT=64 and MAX_PKT=4 instances
// checked every cycle against a stream-level reference model.
module tb_fifo_pkt_writer;

  logic       wclk = 1'b0;
  logic       w_rst_n = 1'b0;
  logic       fifo_full = 1'b0;
  logic [1:0] sv = '0;
  logic [7:0] sd [2];
  logic [1:0] sl = '0;
  logic [1:0] rdy;
  logic [1:0] wen;
  logic [8:0] wdat [2];
  logic [1:0] done;
  logic [1:0] trunc;
  logic [6:0] plen0;
  logic [2:0] plen1;
  logic [15:0] pcnt [2];
  logic [15:0] dcnt [2];

  int checks = 0;
  int errors = 0;

  int mx [2] = '{64, 4};

  // stimulus source
  logic [7:0] bl_d [4096];
  bit         bl_l [4096];
  int         blen = 0;
  int         ptr [2] = '{0, 0};
  bit         acc_prev [2] = '{0, 0};
  int         vprob = 100;
  int         full_mode = 0;
  bit         armed = 0;

  // reference model
  logic [8:0] strm [2][8192];
  int         n_enq [2] = '{0, 0};
  int         n_wr [2] = '{0, 0};
  int         bcnt [2] = '{0, 0};
  int         wl [2] = '{0, 0};
  bit         dropping [2] = '{0, 0};
  bit         e_ready [2] = '{0, 0};
  bit         e_done [2] = '{0, 0};
  bit         e_trunc [2] = '{0, 0};
  int         e_len [2] = '{0, 0};
  int         e_pcnt [2] = '{0, 0};
  int         e_dcnt [2] = '{0, 0};

  initial sd[0] = '0;
  initial sd[1] = '0;

  always #5 wclk = ~wclk;

  fifo_pkt_writer #(.WIDTH(8), .MAX_PKT(64)) u_dut64 (
    .wclk(wclk), .w_rst_n(w_rst_n),
    .s_valid(sv[0]), .s_ready(rdy[0]),
    .s_data(sd[0]), .s_last(sl[0]),
    .fifo_wr_en(wen[0]), .fifo_wr_data(wdat[0]),
    .fifo_full(fifo_full),
    .pkt_done(done[0]), .pkt_len(plen0),
    .trunc_err(trunc[0]),
    .pkt_cnt(pcnt[0]), .drop_cnt(dcnt[0])
  );

  fifo_pkt_writer #(.WIDTH(8), .MAX_PKT(4)) u_dut4 (
    .wclk(wclk), .w_rst_n(w_rst_n),
    .s_valid(sv[1]), .s_ready(rdy[1]),
    .s_data(sd[1]), .s_last(sl[1]),
    .fifo_wr_en(wen[1]), .fifo_wr_data(wdat[1]),
    .fifo_full(fifo_full),
    .pkt_done(done[1]), .pkt_len(plen1),
    .trunc_err(trunc[1]),
    .pkt_cnt(pcnt[1]), .drop_cnt(dcnt[1])
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      if (errors <= 20)
        $display("FAIL %s got %0h exp %0h @%0t", tag, got, exp, $time);
    end
  endtask

  // upstream driver
  always @(negedge wclk) begin
    #1;
    if (full_mode == 2)
      fifo_full = ($urandom_range(1) == 1);
    else
      fifo_full = (full_mode == 1);
    for (int i = 0; i < 2; i++) begin
      if (acc_prev[i] && ptr[i] < blen)
        ptr[i]++;
      if (ptr[i] < blen) begin
        sv[i] = (int'($urandom_range(99)) < vprob);
        sd[i] = bl_d[ptr[i]];
        sl[i] = bl_l[ptr[i]];
      end else begin
        sv[i] = 1'b0;
        sd[i] = '0;
        sl[i] = 1'b0;
      end
    end
  end

  // compare, then advance the model across the coming edge
  always @(negedge wclk) begin
    #4;
    for (int i = 0; i < 2; i++) begin
      int occ;
      int gl;
      bit ew;
      bit tr;
      logic [8:0] w;
      occ = n_enq[i] - n_wr[i];
      ew  = (occ > 0) && !fifo_full;
      gl  = (i == 0) ? int'(plen0) : int'(plen1);
      if (armed) begin
        check($sformatf("%0d:s_ready", i), 32'(rdy[i]), 32'(e_ready[i]));
        check($sformatf("%0d:wr_en", i), 32'(wen[i]), 32'(ew));
        if (ew)
          check($sformatf("%0d:wr_data", i), 32'(wdat[i]),
                32'(strm[i][n_wr[i]]));
        check($sformatf("%0d:pkt_done", i), 32'(done[i]), 32'(e_done[i]));
        if (e_done[i])
          check($sformatf("%0d:pkt_len", i), 32'(gl), 32'(e_len[i]));
        check($sformatf("%0d:trunc_err", i), 32'(trunc[i]),
              32'(e_trunc[i]));
        check($sformatf("%0d:pkt_cnt", i), 32'(pcnt[i]), 32'(e_pcnt[i]));
        check($sformatf("%0d:drop_cnt", i), 32'(dcnt[i]), 32'(e_dcnt[i]));
      end
      acc_prev[i] = w_rst_n && sv[i] && rdy[i];
      if (!w_rst_n) begin
        n_enq[i] = 0; n_wr[i] = 0; bcnt[i] = 0; wl[i] = 0;
        dropping[i] = 0; e_ready[i] = 0; e_done[i] = 0;
        e_trunc[i] = 0; e_len[i] = 0; e_pcnt[i] = 0; e_dcnt[i] = 0;
      end else begin
        e_done[i]  = 0;
        e_trunc[i] = 0;
        if (ew) begin
          w = strm[i][n_wr[i]];
          n_wr[i]++;
          wl[i]++;
          if (w[8]) begin
            e_done[i] = 1;
            e_len[i]  = wl[i];
            e_pcnt[i] = (e_pcnt[i] + 1) % 65536;
            wl[i]     = 0;
          end
        end
        if (sv[i] && e_ready[i]) begin
          if (dropping[i]) begin
            if (e_dcnt[i] != 65535)
              e_dcnt[i]++;
            if (sl[i])
              dropping[i] = 0;
          end else begin
            bcnt[i]++;
            tr = !sl[i] && bcnt[i] == mx[i];
            strm[i][n_enq[i]] = {sl[i] | tr, sd[i]};
            n_enq[i]++;
            if (sl[i] || tr)
              bcnt[i] = 0;
            if (tr) begin
              e_trunc[i]  = 1;
              dropping[i] = 1;
            end
          end
        end
        e_ready[i] = (n_enq[i] - n_wr[i]) < 2;
      end
    end
  end

  task automatic add_pkt(input int n);
    for (int k = 0; k < n; k++) begin
      bl_d[blen] = 8'($urandom);
      bl_l[blen] = (k == n - 1);
      blen++;
    end
  endtask

  task automatic wait_idle(input int budget);
    bit ok;
    ok = 0;
    for (int c = 0; c < budget; c++) begin
      @(negedge wclk);
      if (ptr[0] == blen && ptr[1] == blen &&
          n_enq[0] == n_wr[0] && n_enq[1] == n_wr[1]) begin
        ok = 1;
        break;
      end
    end
    check("idle_wait", 32'(ok), 32'd1);
    repeat (2) @(negedge wclk);
  endtask

  initial begin
    @(negedge wclk);
    armed = 1;
    repeat (2) @(negedge wclk);
    w_rst_n = 1'b1;

    // 3-beat packet, FIFO open
    add_pkt(3);
    wait_idle(200);

    // FIFO full: two beats buffered, then stall, then drain
    full_mode = 1;
    add_pkt(4);
    repeat (8) @(negedge wclk);
    full_mode = 0;
    wait_idle(200);

    // 6-beat packet truncates on the MAX_PKT=4 instance
    add_pkt(6);
    add_pkt(2);
    wait_idle(200);

    // back-to-back single-beat packets
    for (int k = 0; k < 10; k++)
      add_pkt(1);
    wait_idle(200);

    // reset mid-packet with the skid buffer full
    full_mode = 1;
    add_pkt(5);
    repeat (5) @(negedge wclk);
    w_rst_n = 1'b0;
    ptr[0] = blen;
    ptr[1] = blen;
    @(negedge wclk);
    w_rst_n = 1'b1;
    full_mode = 0;
    add_pkt(3);
    wait_idle(200);

    // random backpressure on a 20-beat packet, then random traffic
    full_mode = 2;
    vprob = 70;
    add_pkt(20);
    wait_idle(1000);
    for (int k = 0; k < 40; k++) begin
      vprob = int'($urandom_range(40, 100));
      add_pkt(int'($urandom_range(1, 8)));
    end
    wait_idle(5000);

    full_mode = 0;
    repeat (3) @(negedge wclk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
